// File: rtl/mult_parity_core.sv
// Multiplier responder: req/ack operand capture with even-parity check, iterative
// shift-add multiply on operand magnitudes, and a result_rdy strobe with product parity.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for req; operands captured and parity checked on accept
// CALC  | shift-add iterations, timed by a down-counter to terminal count 0
// DONE  | result/parity/error flags registered, result_rdy strobed
module mult_parity_core #(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [WIDTH-1:0]     arg_a,
    input  logic                 arg_a_parity,
    input  logic [WIDTH-1:0]     arg_b,
    input  logic                 arg_b_parity,
    output logic                 ack,
    output logic [2*WIDTH-1:0]   result,
    output logic                 result_parity,
    output logic                 result_rdy,
    output logic                 arg_parity_error
);

    localparam int CYCLES = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W  = $clog2(CYCLES + 1);
    localparam int PW     = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_step;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [CNT_W-1:0] cnt;
    logic             neg;
    logic             perr;
    logic             perr_in;
    logic             accept;
    logic             step;
    logic             finish;
    logic             ack_next;
    logic             rdy_next;

    assign perr_in = (arg_a_parity != ^arg_a) | (arg_b_parity != ^arg_b);

    // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
    assign mag_a = arg_a[WIDTH-1] ? (WIDTH'(0) - arg_a) : arg_a;
    assign mag_b = arg_b[WIDTH-1] ? (WIDTH'(0) - arg_b) : arg_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        ack_next   = 1'b0;
        rdy_next   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    ack_next   = 1'b1;
                    state_next = perr_in ? DONE : CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                finish     = 1'b1;
                rdy_next   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        acc_step = acc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) begin
                acc_step = acc_step + (mcand << i);
            end
        end
    end

    assign prod = neg ? (PW'(0) - acc) : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack              <= 1'b0;
            result_rdy       <= 1'b0;
            result           <= '0;
            result_parity    <= 1'b0;
            arg_parity_error <= 1'b0;
            mcand            <= '0;
            mplier           <= '0;
            acc              <= '0;
            cnt              <= '0;
            neg              <= 1'b0;
            perr             <= 1'b0;
        end else begin
            ack        <= ack_next;
            result_rdy <= rdy_next;
            if (accept) begin
                mcand  <= {{WIDTH{1'b0}}, mag_a};
                mplier <= mag_b;
                acc    <= '0;
                cnt    <= CNT_W'(CYCLES - 1);
                neg    <= arg_a[WIDTH-1] ^ arg_b[WIDTH-1];
                perr   <= perr_in;
            end
            if (step) begin
                acc    <= acc_step;
                mcand  <= mcand << BITS_PER_CYCLE;
                mplier <= mplier >> BITS_PER_CYCLE;
                cnt    <= cnt - CNT_W'(1);
            end
            // Outputs only change here, so they hold until the next DONE.
            if (finish) begin
                if (perr) begin
                    result           <= '0;
                    result_parity    <= 1'b0;
                    arg_parity_error <= 1'b1;
                end else begin
                    result           <= prod;
                    result_parity    <= ^prod;
                    arg_parity_error <= 1'b0;
                end
            end
        end
    end

endmodule
